// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int unsigned KEY_W              = 4;
   localparam int unsigned ROWS               = 4;
   localparam int unsigned COLS               = 4;
   localparam int unsigned SCAN_DIV_DEF       = 50000;
   localparam int unsigned DEBOUNCE_SCANS_DEF = 4;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HOLD
   } state_t;

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and result signals of the keypad scanner.
interface keypad_scanner_if;
   import keypad_pkg::*;

   logic [COLS-1:0]  col_n;
   logic             clr;
   logic [ROWS-1:0]  row_n;
   logic             key_valid;
   logic [KEY_W-1:0] key_code;
   logic             key_down;
   logic [31:0]      entry_data;

   modport master (
      input  col_n, clr,
      output row_n, key_valid, key_code, key_down, entry_data
   );

   modport slave (
      output col_n, clr,
      input  row_n, key_valid, key_code, key_down, entry_data
   );

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
module keypad_sync
   import keypad_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [COLS-1:0] d,
   output logic [COLS-1:0] q
);

   logic [COLS-1:0] meta_q;
   logic [COLS-1:0] sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with debounce and single-shot press reporting.
// Define KEYPAD_ACCUM_EN to shift accepted digits into entry_data (clr clears it).
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = SCAN_DIV_DEF,
   parameter int unsigned DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   keypad_scanner_if.master kp
);

   localparam int unsigned     DivW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
   localparam logic [3:0]      DbMax  = 4'(DEBOUNCE_SCANS);

   logic [DivW-1:0]  div_q, div_d;
   logic             tick;
   logic [COLS-1:0]  col_s;
   state_t           state_q, state_d;
   logic [1:0]       row_q, row_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [KEY_W-1:0] code_q, code_d;
   logic             valid_q, valid_d;
   logic             down_q, down_d;
   logic             adv_q, adv_d;
   logic             present;
   logic [1:0]       col_idx;
   logic [KEY_W-1:0] code_now;

   keypad_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (kp.col_n),
      .q   (col_s)
   );

   assign tick  = (div_q == DivMax);
   assign div_d = tick ? '0 : div_q + 1'b1;

   // Lowest-index low column wins.
   always_comb begin
      col_idx = 2'd0;
      for (int i = int'(COLS) - 1; i >= 0; i--) begin
         if (!col_s[i]) col_idx = 2'(i);
      end
   end

   assign present  = ~&col_s;
   assign code_now = {row_q, col_idx};

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      code_d  = code_q;
      valid_d = 1'b0;
      down_d  = down_q;
      adv_d   = adv_q;
      if (tick) begin
         case (state_q)
            SCAN: begin
               // adv_q forces one row step after an aborted debounce.
               if (present && !adv_q) begin
                  cand_d  = code_now;
                  cnt_d   = 4'd1;
                  state_d = DEBOUNCE;
               end else begin
                  row_d = row_q + 2'd1;
                  adv_d = 1'b0;
               end
            end
            DEBOUNCE: begin
               if (present && (code_now == cand_q)) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q + 4'd1 == DbMax) begin
                     cnt_d   = '0;
                     state_d = HOLD;
                     valid_d = 1'b1;
                     code_d  = cand_q;
                     down_d  = 1'b1;
                  end
               end else begin
                  state_d = SCAN;
                  adv_d   = 1'b1;
               end
            end
            HOLD: begin
               if (present) begin
                  cnt_d = '0;
               end else if (cnt_q + 4'd1 == DbMax) begin
                  cnt_d   = '0;
                  state_d = SCAN;
                  down_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q   <= '0;
         state_q <= SCAN;
         row_q   <= 2'd0;
         cnt_q   <= '0;
         cand_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         down_q  <= 1'b0;
         adv_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         down_q  <= down_d;
         adv_q   <= adv_d;
      end
   end

   assign kp.row_n     = ~(4'b0001 << row_q);
   assign kp.key_valid = valid_q;
   assign kp.key_code  = code_q;
   assign kp.key_down  = down_q;

`ifdef KEYPAD_ACCUM_EN
   logic [31:0] entry_q, entry_d;

   always_comb begin
      entry_d = entry_q;
      if (valid_q) begin
         entry_d = kp.clr ? {{(32-KEY_W){1'b0}}, code_q} : {entry_q[31-KEY_W:0], code_q};
      end else if (kp.clr) begin
         entry_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) entry_q <= '0;
      else      entry_q <= entry_d;
   end

   assign kp.entry_data = entry_q;
`else
   assign kp.entry_data = {{(32-KEY_W){1'b0}}, code_q};
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int unsigned SD = 4;
   localparam int unsigned DB = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;

   logic        pressed = 1'b0;
   logic [1:0]  prow = 2'd0;
   logic [1:0]  pcol = 2'd0;
   logic [3:0]  cmask;
   logic [31:0] exp_entry = 32'h0;

   always #5 clk = ~clk;

   keypad_scanner_if kp ();

   keypad_scanner #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_SCANS (DB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   // Keypad model: a pressed key pulls its column low only while its row is driven.
   always_comb cmask = ~(4'b0001 << pcol);
   assign kp.col_n = (pressed && (kp.row_n[prow] == 1'b0)) ? cmask : 4'hF;

   always @(posedge clk) if (kp.key_valid === 1'b1) pulses <= pulses + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int maxc, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < maxc) begin
         @(negedge clk);
         n++;
         if (kp.key_valid === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_up(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(negedge clk);
         if (kp.key_down === 1'b0) ok = 1'b1;
      end
   endtask

   // Align to the negedge just after row_n switches to target.
   task automatic wait_row(input logic [3:0] target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && kp.row_n === target; i++) @(negedge clk);
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (kp.row_n === target) ok = 1'b1;
      end
   endtask

   task automatic press_key(input logic [3:0] code, input bit do_clr);
      bit ok;
      int n;
      int p0;
      p0      = pulses;
      prow    = code[3:2];
      pcol    = code[1:0];
      pressed = 1'b1;
      wait_valid(80, ok, n);
      check("press_seen", {31'b0, ok}, 32'd1);
      if (do_clr) kp.clr = 1'b1;
      check("press_code", {28'b0, kp.key_code}, {28'b0, code});
      check("press_down", {31'b0, kp.key_down}, 32'd1);
      @(negedge clk);
      kp.clr  = 1'b0;
      pressed = 1'b0;
      wait_up(40, ok);
      check("release_seen", {31'b0, ok}, 32'd1);
      check("press_pulses", pulses, p0 + 1);
`ifdef KEYPAD_ACCUM_EN
      exp_entry = do_clr ? {28'b0, code} : {exp_entry[27:0], code};
`else
      exp_entry = {28'b0, code};
`endif
      check("press_entry", kp.entry_data, exp_entry);
   endtask

   initial begin
      bit ok;
      int n;
      int p0;
      kp.clr = 1'b0;
      rst    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_row", {28'b0, kp.row_n}, 32'hE);
      check("rst_valid", {31'b0, kp.key_valid}, 32'd0);
      check("rst_code", {28'b0, kp.key_code}, 32'd0);
      check("rst_down", {31'b0, kp.key_down}, 32'd0);
      check("rst_entry", kp.entry_data, 32'd0);

      // Idle scanning: row advances every SD clocks.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("row_pre_tick", {28'b0, kp.row_n}, 32'hE);
      @(negedge clk);
      check("row1", {28'b0, kp.row_n}, 32'hD);
      repeat (4) @(negedge clk);
      check("row2", {28'b0, kp.row_n}, 32'hB);
      repeat (4) @(negedge clk);
      check("row3", {28'b0, kp.row_n}, 32'h7);
      repeat (4) @(negedge clk);
      check("row_wrap", {28'b0, kp.row_n}, 32'hE);
      check("idle_no_pulse", pulses, 0);

      // Row 2 col 1 held for 40 clk.
      p0      = pulses;
      prow    = 2'd2;
      pcol    = 2'd1;
      pressed = 1'b1;
      wait_valid(60, ok, n);
      check("hold_seen", {31'b0, ok}, 32'd1);
      check("hold_code", {28'b0, kp.key_code}, 32'h9);
      check("hold_down", {31'b0, kp.key_down}, 32'd1);
      repeat (40) @(negedge clk);
      check("hold_one_pulse", pulses, p0 + 1);
      check("hold_still_down", {31'b0, kp.key_down}, 32'd1);
      pressed = 1'b0;
      repeat (8) @(negedge clk);
      check("release_early", {31'b0, kp.key_down}, 32'd1);
      wait_up(20, ok);
      check("release_down", {31'b0, ok}, 32'd1);
      exp_entry = 32'h9;
      check("hold_entry", kp.entry_data, exp_entry);

      // Bounce: one tick low, one tick high, then stable.
      p0   = pulses;
      prow = 2'd2;
      pcol = 2'd2;
      wait_row(4'b1011, ok);
      check("bounce_align", {31'b0, ok}, 32'd1);
      pressed = 1'b1;
      repeat (4) @(negedge clk);
      pressed = 1'b0;
      repeat (4) @(negedge clk);
      pressed = 1'b1;
      check("bounce_no_pulse", pulses, p0);
      wait_valid(80, ok, n);
      check("bounce_seen", {31'b0, ok}, 32'd1);
      check("bounce_latency", {31'b0, (n >= 10)}, 32'd1);
      check("bounce_code", {28'b0, kp.key_code}, 32'hA);
      @(negedge clk);
      pressed = 1'b0;
      wait_up(40, ok);
      check("bounce_release", {31'b0, ok}, 32'd1);
      check("bounce_one_pulse", pulses, p0 + 1);
`ifdef KEYPAD_ACCUM_EN
      exp_entry = 32'h9A;
`else
      exp_entry = 32'hA;
`endif
      check("bounce_entry", kp.entry_data, exp_entry);

      // clr alone, then digit entry.
      kp.clr = 1'b1;
      @(negedge clk);
      kp.clr = 1'b0;
      @(negedge clk);
`ifdef KEYPAD_ACCUM_EN
      exp_entry = 32'h0;
`endif
      check("clr_alone", kp.entry_data, exp_entry);
      press_key(4'h1, 1'b0);
      press_key(4'h2, 1'b0);
      press_key(4'h3, 1'b0);
      press_key(4'h4, 1'b0);
`ifdef KEYPAD_ACCUM_EN
      check("entry_1234", kp.entry_data, 32'h00001234);
`endif
      press_key(4'h5, 1'b1);
      check("entry_clr_key5", kp.entry_data, 32'h00000005);
      for (int k = 0; k < 9; k++) press_key(4'hF, 1'b0);
      press_key(4'h1, 1'b0);
`ifdef KEYPAD_ACCUM_EN
      check("entry_ffff_fff1", kp.entry_data, 32'hFFFFFFF1);
`else
      check("entry_last_key", kp.entry_data, 32'h00000001);
`endif

      // Reset during DEBOUNCE.
      p0   = pulses;
      prow = 2'd2;
      pcol = 2'd3;
      wait_row(4'b1011, ok);
      check("rstdb_align", {31'b0, ok}, 32'd1);
      pressed = 1'b1;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rstdb_row", {28'b0, kp.row_n}, 32'hE);
      check("rstdb_valid", {31'b0, kp.key_valid}, 32'd0);
      check("rstdb_code", {28'b0, kp.key_code}, 32'd0);
      check("rstdb_down", {31'b0, kp.key_down}, 32'd0);
      check("rstdb_entry", kp.entry_data, 32'd0);
      pressed = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rstdb_row_hold", {28'b0, kp.row_n}, 32'hE);
      @(negedge clk);
      check("rstdb_row_restart", {28'b0, kp.row_n}, 32'hD);
      repeat (20) @(negedge clk);
      check("rstdb_no_pulse", pulses, p0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
